bht_predictor: RTL
==================

BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 Parameter INDEX_BITS, default 6, SHALL set the table depth to 2^INDEX_BITS two-bit counters; the legal range is 2..10.
REQ-002 Parameter HIST_BITS, default 0, SHALL select the mode: 0 is bimodal, 1..INDEX_BITS is gshare with a HIST_BITS-wide global history; values above INDEX_BITS are illegal.
REQ-003 Parameter CTR_INIT, default 2'b01 (weakly not-taken), SHALL be the counter reset value.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port lookup_branch, input, 1 bit: the decode-stage instruction is a conditional branch.
REQ-007 Port lookup_pc, input, 32 bits: the decode-stage PC.
REQ-008 Port lookup_offset, input, 32 bits: the decode-stage immediate.
REQ-009 Port predict_taken, output, 1 bit: the prediction.
REQ-010 Port predict_target, output, 32 bits: the predicted target address.
REQ-011 Port predict_index, output, INDEX_BITS: the table index used; the pipeline carries it to the resolve stage.
REQ-012 Port update_valid, input, 1 bit: a branch resolves this cycle.
REQ-013 Port update_index, input, INDEX_BITS: predict_index as carried by the pipeline for the resolving branch.
REQ-014 Port update_taken, input, 1 bit: the actual branch outcome.
REQ-015 Port update_predicted, input, 1 bit: predict_taken as carried by the pipeline for the resolving branch.
REQ-016 Port stats_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-017 Port branch_count, output, 32 bits: count of resolved branches.
REQ-018 Port mispredict_count, output, 32 bits: count of mispredicted branches.

Function
REQ-019 The index SHALL be lookup_pc[INDEX_BITS+1:2] XOR the history zero-extended to INDEX_BITS; when HIST_BITS=0 the XOR term SHALL be 0.
REQ-020 Lookup SHALL be combinational with zero-cycle latency.
REQ-021 predict_taken SHALL equal lookup_branch AND counter[index][1].
REQ-022 predict_target SHALL equal lookup_pc + lookup_offset, truncated to 32 bits (wrap-around, no carry out).
REQ-023 predict_index SHALL output the computed index regardless of lookup_branch.
REQ-024 On a clock edge with update_valid=1, counter[update_index] SHALL increment if update_taken=1, saturating at 3, and otherwise decrement, saturating at 0.
REQ-025 Each counter SHALL follow a 4-state FSM: SN(00), WN(01), WT(10), ST(11).
  - Taken transitions: SN->WN->WT->ST, and ST holds.
  - Not-taken transitions: ST->WT->WN->SN, and SN holds.
REQ-026 On a clock edge with update_valid=1 and HIST_BITS>0, the history SHALL shift left with update_taken entering the LSB; otherwise the history SHALL hold.
REQ-027 The history SHALL be non-speculative: lookups SHALL never modify it.
REQ-028 When the lookup and the update hit the same index in the same cycle, the lookup SHALL see the pre-update counter value; there is no bypass.
REQ-029 When the lookup and the update coincide, the lookup SHALL use the pre-shift history.
REQ-030 On each update_valid=1 edge, branch_count SHALL increment.
REQ-031 On each update_valid=1 edge with update_taken != update_predicted, mispredict_count SHALL increment.
REQ-032 Both statistics counters SHALL wrap modulo 2^32.
REQ-033 stats_clr=1 SHALL zero both statistics counters on the next edge and take priority over a simultaneous increment; it SHALL NOT affect the counter table or the history.
REQ-034 With update_valid=0, no state SHALL change other than through stats_clr.

Reset
REQ-035 While rst_n=0, all table counters SHALL be CTR_INIT, the history SHALL be 0, and both statistics counters SHALL be 0, taking effect immediately without waiting for clk.
REQ-036 Assertion of rst_n mid-update SHALL win over any clock edge occurring while rst_n=0.
REQ-037 After rst_n deasserts, the first state change SHALL be on the first rising clk edge that follows.
REQ-038 With CTR_INIT=01, predict_taken SHALL be 0 immediately after reset for every PC.

Verification
REQ-039 Saturation: bimodal, INDEX_BITS=6, PC=0x100, 4 taken updates -> predict_taken goes 0,1,1,1 after updates 1..3, and the counter stays at 3.
  - Then 1 not-taken update -> counter reads 2 and predict_taken stays 1.
REQ-040 Target wrap: lookup_pc=0xFFFFFFF8, offset=0x10 -> predict_target=0x00000008.
REQ-041 Same-index collision: counter at 01; update taken at index 0x00 and lookup PC=0x0 in the same cycle -> predict_taken=0 that cycle and 1 the next cycle.
REQ-042 Gshare: HIST_BITS=2; updates taken then not-taken -> history=2'b10.
  - Lookup PC=0x8 -> predict_index=0x2 XOR 0x2 = 0x0.
REQ-043 Statistics: 5 updates with 2 mismatches -> branch_count=5, mispredict_count=2.
  - stats_clr coincident with an update -> both counters read 0 on the next cycle.
REQ-044 Asynchronous reset: assert rst_n low between clock edges after training -> all outputs return to their reset values before the next edge, and all predictions are 0.

Source files
------------

// File: rtl/bht_predictor_if.sv
// Pipeline-to-predictor bus: decode-stage lookup, resolve-stage update and statistics.
interface bht_predictor_if #(
    parameter int unsigned INDEX_BITS = 6
);
    logic                  lookup_branch;
    logic [31:0]           lookup_pc;
    logic [31:0]           lookup_offset;
    logic                  predict_taken;
    logic [31:0]           predict_target;
    logic [INDEX_BITS-1:0] predict_index;
    logic                  update_valid;
    logic [INDEX_BITS-1:0] update_index;
    logic                  update_taken;
    logic                  update_predicted;
    logic                  stats_clr;
    logic [31:0]           branch_count;
    logic [31:0]           mispredict_count;

    modport master (
        output lookup_branch, lookup_pc, lookup_offset,
        output update_valid, update_index, update_taken, update_predicted, stats_clr,
        input  predict_taken, predict_target, predict_index,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  lookup_branch, lookup_pc, lookup_offset,
        input  update_valid, update_index, update_taken, update_predicted, stats_clr,
        output predict_taken, predict_target, predict_index,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/bht_predictor.sv
// Branch history table predictor: 2-bit saturating counters, bimodal (HIST_BITS=0)
// or gshare (HIST_BITS>0) indexing, non-speculative global history and
// resolved/mispredicted branch statistics.
module bht_predictor #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned HIST_BITS  = 0,
    parameter logic [1:0]  CTR_INIT   = 2'b01
) (
    input logic             clk,
    input logic             rst_n,
    bht_predictor_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << INDEX_BITS;
    localparam int unsigned HW    = (HIST_BITS > 0) ? HIST_BITS : 1;

    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } ctr_state_t;

    ctr_state_t            ctr_mem [DEPTH];
    ctr_state_t            upd_state;
    ctr_state_t            upd_next;
    logic [HW-1:0]         hist;
    logic [INDEX_BITS-1:0] hist_ext;
    logic [INDEX_BITS-1:0] lookup_index;
    logic [1:0]            lookup_bits;
    logic [31:0]           branch_cnt;
    logic [31:0]           mispredict_cnt;

    // History zero-extended to the index width; forced to zero in bimodal mode.
    always_comb begin
        hist_ext = '0;
        if (HIST_BITS > 0) begin
            hist_ext[HW-1:0] = hist;
        end
    end

    // Combinational lookup against the registered (pre-update) table and history.
    always_comb begin
        lookup_index = bus.lookup_pc[INDEX_BITS+1:2] ^ hist_ext;
        lookup_bits  = ctr_mem[lookup_index];
    end

    assign bus.predict_index    = lookup_index;
    assign bus.predict_taken    = bus.lookup_branch & lookup_bits[1];
    assign bus.predict_target   = bus.lookup_pc + bus.lookup_offset;
    assign bus.branch_count     = branch_cnt;
    assign bus.mispredict_count = mispredict_cnt;

    // Next state of the counter addressed by the resolving branch.
    always_comb begin
        upd_state = ctr_mem[bus.update_index];
        upd_next  = upd_state;
        case (upd_state)
            SN:      upd_next = bus.update_taken ? WN : SN;
            WN:      upd_next = bus.update_taken ? WT : SN;
            WT:      upd_next = bus.update_taken ? ST : WN;
            ST:      upd_next = bus.update_taken ? ST : WT;
            default: upd_next = upd_state;
        endcase
    end

    // Counter table state register; only the resolving entry changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr_mem[i] <= ctr_state_t'(CTR_INIT);
            end
        end else if (bus.update_valid) begin
            ctr_mem[bus.update_index] <= upd_next;
        end
    end

    // Global history shifts in resolved outcomes only, never on lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if ((HIST_BITS > 0) && bus.update_valid) begin
            hist <= HW'({hist, bus.update_taken});
        end
    end

    // Statistics counters; clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (bus.stats_clr) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (bus.update_valid) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (bus.update_taken != bus.update_predicted) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end
endmodule
